// File: rtl/div32_seq.sv
// Sequential unsigned restoring divider: quotient and remainder, one quotient bit per clock, MSB first.
// Latency: WIDTH cycles from the acceptance edge to done; a zero divisor completes in the next cycle.
// Backpressure: start is taken only while busy=0, which includes the done cycle; start during RUN is dropped.
module div32_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic             div_zero;
   logic [CW-1:0]    cnt;
   // The partial remainder is always below the divisor after a step, so its
   // top bit is only ever nonzero in the shifted (WIDTH+1)-bit compare value.
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   p_shift;
   logic             ge;
   logic [WIDTH-1:0] p_next;
   logic [WIDTH-1:0] q_next;

   // One restoring step: shift in the next dividend bit, compare, subtract if it fits.
   always_comb begin
      p_shift = {p, q[WIDTH-1]};
      ge      = (p_shift >= {1'b0, dvs});
      p_next  = ge ? (p_shift[WIDTH-1:0] - dvs) : p_shift[WIDTH-1:0];
      q_next  = {q[WIDTH-2:0], ge};
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nxt = state;
      accept    = start && (state != RUN);
      div_zero  = (divisor == '0);
      busy      = (state == RUN);
      done      = (state == DONE);
      case (state)
         IDLE, DONE: begin
            if (accept)             state_nxt = div_zero ? DONE : RUN;
            else if (state == DONE) state_nxt = IDLE;
         end
         RUN: begin
            if (cnt == '0) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, iteration registers and result registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt         <= '0;
         p           <= '0;
         q           <= '0;
         dvs         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         if (div_zero) begin
            // No iteration: results are defined directly at the acceptance edge.
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            cnt <= CNT_INIT;
            p   <= '0;
            q   <= dividend;
            dvs <= divisor;
         end
      end else if (state == RUN) begin
         p   <= p_next;
         q   <= q_next;
         cnt <= cnt - 1'b1;
         // Final step: publish results; they hold until the next completion.
         if (cnt == '0) begin
            quotient    <= q_next;
            remainder   <= p_next;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: directed vector table, handshake corner sequences, random regression.
// Latency: each operation is timed in edges from acceptance to the first observed done.
// Backpressure: exercises start during RUN (dropped) and start during DONE (accepted).
module tb_div32_seq;

   logic        clk;
   logic        rstn;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   int n_cmp;
   int n_bad;

   // Last completed result as known to the bench; outputs must hold it while an op runs.
   logic [31:0] pq;
   logic [31:0] pr;
   logic        pz;

   div32_seq #(.WIDTH(32)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one operation. With b2b set the caller is already at the done-cycle
   // negedge and start is driven in that cycle. lat counts edges after the
   // acceptance edge until done is first seen; bcnt counts busy samples before it.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit b2b,
                        output logic [31:0] rq, output logic [31:0] rr, output logic rz,
                        output int lat, output int bcnt, output bit stable);
      if (!b2b) @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      lat      = 0;
      bcnt     = 0;
      stable   = 1'b1;
      while (!done && lat < 100) begin
         if (busy) bcnt++;
         if (quotient !== pq || remainder !== pr || div_by_zero !== pz) stable = 1'b0;
         @(negedge clk);
         lat++;
      end
      rq = quotient;
      rr = remainder;
      rz = div_by_zero;
   endtask

   task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eq, input logic [31:0] er, input logic ez,
                            input bit b2b, output logic [31:0] rq, output logic [31:0] rr);
      logic rz;
      int   lat;
      int   bcnt;
      bit   stable;
      do_op(a, b, b2b, rq, rr, rz, lat, bcnt, stable);
      chk({tag, " quotient"},    64'(rq), 64'(eq));
      chk({tag, " remainder"},   64'(rr), 64'(er));
      chk({tag, " div_by_zero"}, 64'(rz), 64'(ez));
      chk({tag, " latency"},     64'(lat),  ez ? 64'd0 : 64'd32);
      chk({tag, " busy cycles"}, 64'(bcnt), ez ? 64'd0 : 64'd32);
      chk({tag, " hold during run"}, 64'(stable), 64'd1);
      pq = eq;
      pr = er;
      pz = ez;
   endtask

   initial begin
      vec_t        vecs[10];
      logic [31:0] rq;
      logic [31:0] rr;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eq;
      logic [31:0] er;
      int          k;
      bit          seen;

      n_cmp    = 0;
      n_bad    = 0;
      pq       = '0;
      pr       = '0;
      pz       = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      rstn     = 1'b0;

      vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          z: 1'b0};
      vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,          z: 1'b0};
      vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,          z: 1'b0};
      vecs[3] = '{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3,          z: 1'b0};
      vecs[4] = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5,          z: 1'b1};
      vecs[5] = '{a: 32'd9,          b: 32'd3,          q: 32'd3,          r: 32'd0,          z: 1'b0};
      vecs[6] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,          z: 1'b0};
      vecs[7] = '{a: 32'h8000_0000,  b: 32'd2,          q: 32'h4000_0000,  r: 32'd0,          z: 1'b0};
      vecs[8] = '{a: 32'd12345678,   b: 32'd1000,       q: 32'd12345,      r: 32'd678,        z: 1'b0};
      vecs[9] = '{a: 32'hFFFF_FFFE,  b: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'hFFFF_FFFE,  z: 1'b0};

      // Reset state.
      #12;
      chk("reset busy",        64'(busy),        64'd0);
      chk("reset done",        64'(done),        64'd0);
      chk("reset quotient",    64'(quotient),    64'd0);
      chk("reset remainder",   64'(remainder),   64'd0);
      chk("reset div_by_zero", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Directed vector table.
      foreach (vecs[i])
         run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                   vecs[i].z, 1'b0, rq, rr);

      // start with new operands at RUN cycle 5 must be ignored.
      @(negedge clk);
      dividend = 32'd1000;
      divisor  = 32'd10;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k     = 0;
      while (!done && k < 100) begin
         if (k == 5) begin
            dividend = 32'd50;
            divisor  = 32'd5;
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk("ignored start latency",   64'(k),         64'd32);
      chk("ignored start quotient",  64'(quotient),  64'd100);
      chk("ignored start remainder", 64'(remainder), 64'd0);
      pq = 32'd100;
      pr = 32'd0;
      pz = 1'b0;

      // Back-to-back: start held during the done cycle is accepted.
      run_check("b2b first", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, rq, rr);
      run_check("b2b second", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1, rq, rr);
      // Zero divisor accepted in DONE: done stays high for a second cycle.
      run_check("b2b zero", 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1, 1'b1, rq, rr);

      // Reset in the middle of RUN: outputs clear at once, no done for the aborted op.
      @(negedge clk);
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midrun reset busy",        64'(busy),        64'd0);
      chk("midrun reset done",        64'(done),        64'd0);
      chk("midrun reset quotient",    64'(quotient),    64'd0);
      chk("midrun reset remainder",   64'(remainder),   64'd0);
      chk("midrun reset div_by_zero", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (busy || done) seen = 1'b1;
      end
      chk("aborted op stays quiet", 64'(seen), 64'd0);
      pq = '0;
      pr = '0;
      pz = 1'b0;

      // Random regression against a reference model.
      for (int n = 0; n < 250; n++) begin
         a = $urandom;
         if ($urandom_range(99) < 5) b = '0;
         else                        b = 32'($urandom) >> $urandom_range(31);
         if (b == '0) begin
            eq = '1;
            er = a;
         end else begin
            eq = a / b;
            er = a % b;
         end
         run_check($sformatf("rand%0d", n), a, b, eq, er, (b == '0), 1'b0, rq, rr);
         if (b != '0) begin
            chk($sformatf("rand%0d identity", n), (64'(rq) * 64'(b)) + 64'(rr), 64'(a));
            chk($sformatf("rand%0d rem<div", n), 64'(rr < b), 64'd1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
